wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Merges the two superscalar writeback lanes (A = older, B = younger) onto the single
//  register-file write port. Conflicting writes are buffered in program order in a small
//  queue. A query port returns the youngest pending value so that decode can forward
//  writes that have not yet reached the register file. Sits between WB and the register file.
// PARAMETERS
//  DEPTH  4   queue entries, power of two, >= 2
//  AW     2   queue pointer width, log2(DEPTH)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  a_valid     in   1   lane A write request
//  a_reg       in   5   lane A destination register
//  a_data      in   32  lane A write data
//  b_valid     in   1   lane B write request (younger than A)
//  b_reg       in   5   lane B destination register
//  b_data      in   32  lane B write data
//  stall       out  1   upstream must hold both valids low next cycle
//  RegWrite    out  1   register-file write enable (registered)
//  write_reg   out  5   register-file write address (registered)
//  write_data  out  32  register-file write data (registered)
//  q_reg       in   5   forwarding query register
//  q_hit       out  1   a pending write to q_reg exists (combinational)
//  q_data      out  32  data of the youngest pending write to q_reg
//  overflow    out  1   sticky error flag: a write was lost
// BEHAVIOUR
//  - Reset (async, rst_n=0): RegWrite=0, write_reg=0, write_data=0, queue empty,
//    count=0, overflow=0. The queue contents themselves are not reset.
//  - Filtering: a lane whose valid=1 and reg=0 is discarded. It is never queued and never hits.
//  - Ordering: the effective incoming set is {A, B} in that order, after filtering.
//    Queued entries are always older than incoming ones.
//  - Each posedge produces exactly one output write when any work exists:
//    * queue non-empty: pop the head into the output register; append incoming A, then B.
//    * queue empty: the first incoming write goes directly to the output register
//      (1-cycle latency); the second one, if any, is enqueued.
//    * nothing pending: RegWrite <= 0. write_reg and write_data hold their values.
//  - Count update per cycle: count + pushes - pop. Range 0..DEPTH. Pointers wrap modulo DEPTH.
//  - stall = (count >= DEPTH-1). This guarantees room for 2 pushes with 1 pop.
//    stall is combinational from count.
//  - Inputs while stalled: if a push would exceed DEPTH, the excess write(s) are dropped
//    (B is dropped before A) and overflow <= 1. overflow clears only on reset.
//  - Query: candidates are the output register (when RegWrite=1) and the valid queue entries.
//    The youngest match wins: the queue tail side first, then toward the head, then the output
//    register. If no match: q_hit=0 and q_data=0. q_reg=0 never hits.
//    The query does not include lane A or lane B inputs of the same cycle.
//  - Same-register writes A and B in one cycle are both issued, in order. No coalescing.
//  - Reset mid-operation discards all pending writes; RegWrite falls immediately (async).
// TESTING
//  1. Reset, then A=(r5,0x11) only -> next cycle RegWrite=1, write_reg=5, write_data=0x11;
//     the cycle after, RegWrite=0.
//  2. A=(r3,0xA) and B=(r4,0xB) in one cycle -> output r3/0xA, then r4/0xB on consecutive
//     cycles; q_reg=4 hits 0xB between the two.
//  3. Three back-to-back dual pushes with DEPTH=4 -> stall rises when count=3; all six writes
//     leave in order A0,B0,A1,B1,A2,B2; overflow=0.
//  4. Ignore stall: push dual writes while count=4 -> B dropped first, overflow=1 and it
//     stays set until rst_n=0.
//  5. Queue holds r7=0x1 (older) and r7=0x2 (younger); q_reg=7 -> q_hit=1, q_data=0x2;
//     A=(r0,0xFF) -> never written, never hits.
//  6. Assert rst_n=0 mid-drain with 3 queued writes -> RegWrite=0 immediately; after release,
//     no stale writes appear and stall=0.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - writeback lanes, register-file write port and forwarding query bundle
interface wb_write_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  q_reg;
  logic        q_hit;
  logic [31:0] q_data;
  logic        overflow;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, q_reg,
    output stall, RegWrite, write_reg, write_data, q_hit, q_data, overflow
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, q_reg,
    input  stall, RegWrite, write_reg, write_data, q_hit, q_data, overflow
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges two writeback lanes onto one register-file write port
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                clk,
  input logic                rst_n,
  wb_write_arbiter_if.slave  wb_if
);

  logic [4:0]    mem_reg_q  [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          overflow_q, overflow_d;

  logic          a_eff, b_eff, pop, drop;
  logic [1:0]    want, accept;
  logic [AW+1:0] slots;
  logic [4:0]    push0_reg, push1_reg;
  logic [31:0]   push0_data, push1_data;

  always_comb begin
    a_eff        = wb_if.a_valid && (wb_if.a_reg != 5'd0);
    b_eff        = wb_if.b_valid && (wb_if.b_reg != 5'd0);
    pop          = (count_q != '0);
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    want         = 2'd0;
    push0_reg    = wb_if.a_reg;
    push0_data   = wb_if.a_data;
    push1_reg    = wb_if.b_reg;
    push1_data   = wb_if.b_data;
    // Queued entries are older than incoming ones, so the head always leaves first.
    if (pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = mem_reg_q[head_q];
      write_data_d = mem_data_q[head_q];
      if (a_eff && b_eff) begin
        want = 2'd2;
      end else if (a_eff) begin
        want = 2'd1;
      end else if (b_eff) begin
        want       = 2'd1;
        push0_reg  = wb_if.b_reg;
        push0_data = wb_if.b_data;
      end
    end else if (a_eff) begin
      reg_write_d  = 1'b1;
      write_reg_d  = wb_if.a_reg;
      write_data_d = wb_if.a_data;
      if (b_eff) begin
        want       = 2'd1;
        push0_reg  = wb_if.b_reg;
        push0_data = wb_if.b_data;
      end
    end else if (b_eff) begin
      reg_write_d  = 1'b1;
      write_reg_d  = wb_if.b_reg;
      write_data_d = wb_if.b_data;
    end
    // Slot freed by the pop is reusable this cycle; excess pushes lose the younger write.
    slots      = (AW+2)'(DEPTH) - {1'b0, count_q} + {{(AW+1){1'b0}}, pop};
    drop       = ((AW+2)'(want) > slots);
    accept     = drop ? slots[1:0] : want;
    tail_d     = tail_q + AW'(accept);
    head_d     = head_q + AW'(pop);
    count_d    = count_q + (AW+1)'(accept) - (AW+1)'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      overflow_q   <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept != 2'd0) begin
      mem_reg_q[tail_q]  <= push0_reg;
      mem_data_q[tail_q] <= push0_data;
    end
    if (accept == 2'd2) begin
      mem_reg_q[tail_q + AW'(1)]  <= push1_reg;
      mem_data_q[tail_q + AW'(1)] <= push1_data;
    end
  end

  // Scan oldest to youngest so the last match (nearest the tail) wins.
  always_comb begin
    wb_if.q_hit  = 1'b0;
    wb_if.q_data = 32'd0;
    if (wb_if.q_reg != 5'd0) begin
      if (reg_write_q && (write_reg_q == wb_if.q_reg)) begin
        wb_if.q_hit  = 1'b1;
        wb_if.q_data = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (((AW+1)'(i) < count_q) && (mem_reg_q[head_q + AW'(i)] == wb_if.q_reg)) begin
          wb_if.q_hit  = 1'b1;
          wb_if.q_data = mem_data_q[head_q + AW'(i)];
        end
      end
    end
  end

  assign wb_if.stall      = (count_q >= (AW+1)'(DEPTH - 1));
  assign wb_if.RegWrite   = reg_write_q;
  assign wb_if.write_reg  = write_reg_q;
  assign wb_if.write_data = write_data_q;
  assign wb_if.overflow   = overflow_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - vector table, scoreboard and corner-case sequences for wb_write_arbiter
module tb_wb_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_arbiter_if wb_if ();

  wb_write_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_if (wb_if)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    int          exp_n;
    logic [4:0]  e0r;
    logic [31:0] e0d;
    logic [4:0]  e1r;
    logic [31:0] e1d;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic bv, input logic [4:0] br, input logic [31:0] bd);
    wb_if.a_valid = av; wb_if.a_reg = ar; wb_if.a_data = ad;
    wb_if.b_valid = bv; wb_if.b_reg = br; wb_if.b_data = bd;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    sb.push_back(w);
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_three();
    drv(1, 5'd1, 32'hA0, 1, 5'd2, 32'hB0); expect_wr(1, 32'hA0); expect_wr(2, 32'hB0);
    @(negedge clk);
    chk("fill_stall_c1", wb_if.stall, 1'b0);
    drv(1, 5'd3, 32'hA1, 1, 5'd4, 32'hB1); expect_wr(3, 32'hA1); expect_wr(4, 32'hB1);
    @(negedge clk);
    chk("fill_stall_c2", wb_if.stall, 1'b0);
    drv(1, 5'd5, 32'hA2, 1, 5'd6, 32'hB2); expect_wr(5, 32'hA2); expect_wr(6, 32'hB2);
    @(negedge clk);
    chk("fill_stall_c3", wb_if.stall, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_if.RegWrite) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", wb_if.write_reg, wb_if.write_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_write_reg", wb_if.write_reg, e.r);
        chk("sb_write_data", wb_if.write_data, e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 5'd5, 32'h11, 0, 5'd0, 32'h0,  1, 5'd5, 32'h11, 5'd0, 32'h0};
    vecs[1] = '{0, 5'd0, 32'h0,  1, 5'd6, 32'h22, 1, 5'd6, 32'h22, 5'd0, 32'h0};
    vecs[2] = '{1, 5'd3, 32'hA,  1, 5'd4, 32'hB,  2, 5'd3, 32'hA,  5'd4, 32'hB};
    vecs[3] = '{1, 5'd0, 32'hFF, 1, 5'd8, 32'h88, 1, 5'd8, 32'h88, 5'd0, 32'h0};
    vecs[4] = '{1, 5'd0, 32'h1,  1, 5'd0, 32'h2,  0, 5'd0, 32'h0,  5'd0, 32'h0};
    vecs[5] = '{1, 5'd2, 32'h5,  1, 5'd2, 32'h6,  2, 5'd2, 32'h5,  5'd2, 32'h6};
    vecs[6] = '{0, 5'd9, 32'h99, 1, 5'd31, 32'h7, 1, 5'd31, 32'h7, 5'd0, 32'h0};

    drv(0, 0, 0, 0, 0, 0);
    wb_if.q_reg = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_regwrite", wb_if.RegWrite, 1'b0);
    chk("rst_write_reg", wb_if.write_reg, 5'd0);
    chk("rst_write_data", wb_if.write_data, 32'd0);
    chk("rst_stall", wb_if.stall, 1'b0);
    chk("rst_overflow", wb_if.overflow, 1'b0);
    chk("rst_q_hit", wb_if.q_hit, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drv(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      if (vecs[i].exp_n >= 1) expect_wr(vecs[i].e0r, vecs[i].e0d);
      if (vecs[i].exp_n == 2) expect_wr(vecs[i].e1r, vecs[i].e1d);
      @(negedge clk);
      chk($sformatf("vec%0d_regwrite", i), wb_if.RegWrite, (vecs[i].exp_n > 0));
      idle(4);
      chk($sformatf("vec%0d_drained", i), sb.size(), 0);
    end

    drv(1, 5'd5, 32'h11, 0, 0, 0); expect_wr(5, 32'h11);
    @(negedge clk);
    chk("t1_regwrite", wb_if.RegWrite, 1'b1);
    chk("t1_write_reg", wb_if.write_reg, 5'd5);
    chk("t1_write_data", wb_if.write_data, 32'h11);
    idle(1);
    chk("t1_regwrite_low", wb_if.RegWrite, 1'b0);
    chk("t1_write_reg_hold", wb_if.write_reg, 5'd5);

    drv(1, 5'd3, 32'hA, 1, 5'd4, 32'hB); expect_wr(3, 32'hA); expect_wr(4, 32'hB);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    wb_if.q_reg = 5'd4; #1;
    chk("t2_q4_hit", wb_if.q_hit, 1'b1);
    chk("t2_q4_data", wb_if.q_data, 32'hB);
    wb_if.q_reg = 5'd3; #1;
    chk("t2_q3_hit", wb_if.q_hit, 1'b1);
    chk("t2_q3_data", wb_if.q_data, 32'hA);
    idle(2);
    wb_if.q_reg = 5'd4; #1;
    chk("t2_q4_gone", wb_if.q_hit, 1'b0);
    chk("t2_q4_gone_data", wb_if.q_data, 32'd0);

    fill_three();
    idle(6);
    chk("t3_stall_after", wb_if.stall, 1'b0);
    chk("t3_overflow", wb_if.overflow, 1'b0);
    chk("t3_drained", sb.size(), 0);

    fill_three();
    drv(1, 5'd7, 32'hC0, 1, 5'd8, 32'hC1); expect_wr(7, 32'hC0); expect_wr(8, 32'hC1);
    @(negedge clk);
    chk("t4_overflow_full", wb_if.overflow, 1'b0);
    chk("t4_stall_full", wb_if.stall, 1'b1);
    drv(1, 5'd9, 32'hD0, 1, 5'd10, 32'hD1); expect_wr(9, 32'hD0);
    @(negedge clk);
    chk("t4_overflow_set", wb_if.overflow, 1'b1);
    idle(8);
    chk("t4_overflow_sticky", wb_if.overflow, 1'b1);
    chk("t4_drained", sb.size(), 0);
    do_reset();
    #1;
    chk("t4_overflow_cleared", wb_if.overflow, 1'b0);

    drv(1, 5'd9, 32'h9, 1, 5'd12, 32'hC); expect_wr(9, 32'h9); expect_wr(12, 32'hC);
    @(negedge clk);
    drv(1, 5'd7, 32'h1, 1, 5'd7, 32'h2); expect_wr(7, 32'h1); expect_wr(7, 32'h2);
    @(negedge clk);
    drv(1, 5'd0, 32'hFF, 0, 0, 0);
    wb_if.q_reg = 5'd7; #1;
    chk("t5_q7_hit", wb_if.q_hit, 1'b1);
    chk("t5_q7_youngest", wb_if.q_data, 32'h2);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    wb_if.q_reg = 5'd0; #1;
    chk("t5_q0_hit", wb_if.q_hit, 1'b0);
    chk("t5_q0_data", wb_if.q_data, 32'd0);
    wb_if.q_reg = 5'd7; #1;
    chk("t5_q7_over_out", wb_if.q_data, 32'h2);
    wb_if.q_reg = 5'd12; #1;
    chk("t5_q12_miss", wb_if.q_hit, 1'b0);
    idle(4);
    chk("t5_drained", sb.size(), 0);

    fill_three();
    drv(0, 0, 0, 0, 0, 0);
    chk("t6_regwrite_before", wb_if.RegWrite, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_regwrite_async", wb_if.RegWrite, 1'b0);
    chk("t6_stall_async", wb_if.stall, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("t6_stall_after", wb_if.stall, 1'b0);
    chk("t6_no_stale", wb_if.RegWrite, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
